// File: rtl/wavelet_pkg.sv
// Shared wavelet filter-bank tables, pipeline tag type and FSM encoding.
// The coefficient ROM, the tap mux and the MAC scheduler all use these tables.
package wavelet_pkg;

    localparam int NUM_FILTERS = 8;
    localparam int TOTAL_MACS  = 324;
    localparam int FID_W       = 3;
    localparam int OUT_BITS    = 8;

    localparam int NUM_TAPS  [NUM_FILTERS] = '{3, 5, 9, 15, 26, 46, 80, 140};
    localparam int COEF_BASE [NUM_FILTERS] = '{0, 3, 8, 17, 32, 58, 104, 184};
    localparam int MAX_BITS  [NUM_FILTERS] = '{16, 16, 16, 17, 18, 19, 19, 20};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } fsm_state_t;

    typedef struct packed {
        logic             valid;
        logic             first;
        logic             last;
        logic [FID_W-1:0] fid;
    } mac_tag_t;

    function automatic logic [7:0] last_tap_idx(input logic [FID_W-1:0] f);
        return 8'(NUM_TAPS[f] - 1);
    endfunction

    // LSB position of the 8-bit output window inside the accumulator
    function automatic logic [4:0] trunc_shift(input logic [FID_W-1:0] f);
        return 5'(MAX_BITS[f] - OUT_BITS);
    endfunction

endpackage

// File: rtl/mac_accumulator.sv
// Signed multiply, load/accumulate and per-channel truncated result write.
// Inputs are the tap/coef data together with the tag aligned to that data.
module mac_accumulator #(
    parameter int BITS_PER_ELEM  = 8,
    parameter int NUM_FILTERS    = 8,
    parameter int SUM_TRUNCATION = 8,
    parameter int ACC_BITS       = 24
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic signed [BITS_PER_ELEM-1:0]         tap,
    input  logic signed [BITS_PER_ELEM-1:0]         coef,
    input  logic                                    valid,
    input  logic                                    first,
    input  logic                                    last,
    input  logic [2:0]                              fid,
    output logic [NUM_FILTERS*SUM_TRUNCATION-1:0]   wavelet
);
    import wavelet_pkg::*;

    localparam int PW = 2 * BITS_PER_ELEM;

    logic signed [PW-1:0]       product;
    logic signed [ACC_BITS-1:0] product_ext;
    logic signed [ACC_BITS-1:0] acc;
    logic signed [ACC_BITS-1:0] acc_next;
    logic [SUM_TRUNCATION-1:0]  trunc;

    assign product     = $signed({{BITS_PER_ELEM{tap[BITS_PER_ELEM-1]}}, tap})
                       * $signed({{BITS_PER_ELEM{coef[BITS_PER_ELEM-1]}}, coef});
    assign product_ext = {{(ACC_BITS-PW){product[PW-1]}}, product};
    assign acc_next    = first ? product_ext : acc + product_ext;
    // the result write uses the sum including the final product
    assign trunc       = acc_next[trunc_shift(fid) +: SUM_TRUNCATION];

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc     <= '0;
            wavelet <= '0;
        end else if (valid) begin
            acc <= acc_next;
            if (last) begin
                for (int f = 0; f < NUM_FILTERS; f++) begin
                    if (int'(fid) == f)
                        wavelet[f*SUM_TRUNCATION +: SUM_TRUNCATION] <= trunc;
                end
            end
        end
    end

endmodule

// File: rtl/fir_mac_scheduler.sv
// Sequences the 8-channel wavelet FIR bank through one shared MAC.
// One tap/coef address pair per cycle; data returns one cycle after its address.
//
//   state    | meaning
//   ST_IDLE  | waiting for i_start_calc, addresses held at 0
//   ST_ISSUE | issuing 324 address pairs back to back
//   ST_DRAIN | last product in flight, waiting for channel 7 write
module fir_mac_scheduler #(
    parameter int BITS_PER_ELEM  = 8,
    parameter int NUM_FILTERS    = 8,
    parameter int SUM_TRUNCATION = 8,
    parameter int ACC_BITS       = 24
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    i_start_calc,
    output logic [10:0]                             o_tap_addr,
    output logic [8:0]                              o_coef_addr,
    input  logic signed [BITS_PER_ELEM-1:0]         i_tap,
    input  logic signed [BITS_PER_ELEM-1:0]         i_coef,
    output logic [NUM_FILTERS*SUM_TRUNCATION-1:0]   o_wavelet,
    output logic                                    o_busy,
    output logic                                    o_done,
    output logic                                    o_overrun
);
    import wavelet_pkg::*;

    fsm_state_t state, state_next;

    logic [2:0] filt;
    logic [7:0] tap_idx;
    logic [8:0] coef_idx;
    mac_tag_t   tag_a, tag_b;

    logic       issue_last_tap, issue_last, final_write;
    logic       nxt_valid;
    logic [2:0] nxt_filt;
    logic [7:0] nxt_tap;
    logic [8:0] nxt_coef;

    assign issue_last_tap = (tap_idx == last_tap_idx(filt));
    assign issue_last     = (coef_idx == 9'(TOTAL_MACS - 1));
    assign final_write    = tag_b.valid && tag_b.last && (tag_b.fid == 3'(NUM_FILTERS - 1));

    always_ff @(posedge clk) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (i_start_calc) state_next = ST_ISSUE;
            ST_ISSUE: if (issue_last)   state_next = ST_DRAIN;
            ST_DRAIN: if (final_write)  state_next = ST_IDLE;
            default:                    state_next = ST_IDLE;
        endcase
    end

    // next registered address; all zeros whenever nothing is being issued
    always_comb begin
        nxt_valid = 1'b0;
        nxt_filt  = '0;
        nxt_tap   = '0;
        nxt_coef  = '0;
        o_busy    = (state != ST_IDLE);
        case (state)
            ST_IDLE: nxt_valid = i_start_calc;
            ST_ISSUE: begin
                if (!issue_last) begin
                    nxt_valid = 1'b1;
                    nxt_coef  = coef_idx + 9'd1;
                    if (issue_last_tap) begin
                        nxt_filt = filt + 3'd1;
                    end else begin
                        nxt_filt = filt;
                        nxt_tap  = tap_idx + 8'd1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            filt      <= '0;
            tap_idx   <= '0;
            coef_idx  <= '0;
            tag_a     <= '0;
            tag_b     <= '0;
            o_done    <= 1'b0;
            o_overrun <= 1'b0;
        end else begin
            filt     <= nxt_filt;
            tap_idx  <= nxt_tap;
            coef_idx <= nxt_coef;
            tag_a    <= '{valid: nxt_valid,
                          first: (nxt_tap == 8'd0),
                          last:  (nxt_tap == last_tap_idx(nxt_filt)),
                          fid:   nxt_filt};
            tag_b    <= tag_a;
            o_done   <= final_write;
            if (i_start_calc && state != ST_IDLE)
                o_overrun <= 1'b1;
        end
    end

    assign o_tap_addr  = {3'b000, tap_idx};
    assign o_coef_addr = coef_idx;

    mac_accumulator #(
        .BITS_PER_ELEM  (BITS_PER_ELEM),
        .NUM_FILTERS    (NUM_FILTERS),
        .SUM_TRUNCATION (SUM_TRUNCATION),
        .ACC_BITS       (ACC_BITS)
    ) u_mac (
        .clk     (clk),
        .rst     (rst),
        .tap     (i_tap),
        .coef    (i_coef),
        .valid   (tag_b.valid),
        .first   (tag_b.first),
        .last    (tag_b.last),
        .fid     (tag_b.fid),
        .wavelet (o_wavelet)
    );

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Scoreboarded bench for fir_mac_scheduler: frame results are predicted from
// the filter-bank sums and checked by a monitor on every o_done pulse.
module tb_fir_mac_scheduler;

    localparam int NF = 8;
    localparam int N_TAB    [8] = '{3, 5, 9, 15, 26, 46, 80, 140};
    localparam int BASE_TAB [8] = '{0, 3, 8, 17, 32, 58, 104, 184};
    localparam int MB_TAB   [8] = '{16, 16, 16, 17, 18, 19, 19, 20};

    logic               clk = 1'b0;
    logic               rst;
    logic               i_start_calc;
    logic [10:0]        o_tap_addr;
    logic [8:0]         o_coef_addr;
    logic signed [7:0]  i_tap;
    logic signed [7:0]  i_coef;
    logic [63:0]        o_wavelet;
    logic               o_busy, o_done, o_overrun;

    int cyc   = 0;
    int n_cmp = 0;
    int n_bad = 0;

    byte tap_mem  [140];
    byte coef_mem [324];

    typedef struct {
        int          cyc;
        logic [63:0] w;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [63:0] prev_w;
    int          tr_tap[$];
    int          tr_coef[$];

    fir_mac_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .i_start_calc (i_start_calc),
        .o_tap_addr   (o_tap_addr),
        .o_coef_addr  (o_coef_addr),
        .i_tap        (i_tap),
        .i_coef       (i_coef),
        .o_wavelet    (o_wavelet),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_overrun    (o_overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // external tap mux and coefficient ROM, one cycle read latency
    always @(posedge clk) begin
        i_tap  <= (o_tap_addr  < 11'd140) ? tap_mem[o_tap_addr]   : 8'sd0;
        i_coef <= (o_coef_addr < 9'd324)  ? coef_mem[o_coef_addr] : 8'sd0;
    end

    function automatic logic [63:0] model_frame();
        logic [63:0] w;
        longint      acc;
        w = '0;
        for (int f = 0; f < NF; f++) begin
            acc = 0;
            for (int i = 0; i < N_TAB[f]; i++)
                acc += longint'(tap_mem[i]) * longint'(coef_mem[BASE_TAB[f] + i]);
            acc = acc & 64'h00FF_FFFF;
            w[8*f +: 8] = 8'(acc >> (MB_TAB[f] - 8));
        end
        return w;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        exp_t e;
        e.cyc = cyc + 326;
        e.w   = model_frame();
        exp_q.push_back(e);
        prev_w = e.w;
        i_start_calc = 1'b1;
        tick();
        i_start_calc = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((o_busy || exp_q.size() != 0) && n < 2000) begin
            tick();
            n++;
        end
        n_cmp++;
        if (n >= 2000) begin
            n_bad++;
            $display("FAIL idle_timeout: busy=%0b pending=%0d want idle with none pending", o_busy, exp_q.size());
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < 140; i++) tap_mem[i]  = byte'($urandom_range(0, 255));
        for (int i = 0; i < 324; i++) coef_mem[i] = byte'($urandom_range(0, 255));
    endtask

    task automatic fill_const(input byte t, input byte c);
        for (int i = 0; i < 140; i++) tap_mem[i]  = t;
        for (int i = 0; i < 324; i++) coef_mem[i] = c;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"},     64'(o_busy),      64'd0);
        check({tag, "_done"},     64'(o_done),      64'd0);
        check({tag, "_overrun"},  64'(o_overrun),   64'd0);
        check({tag, "_tap_addr"}, 64'(o_tap_addr),  64'd0);
        check({tag, "_coef_addr"},64'(o_coef_addr), 64'd0);
        check({tag, "_wavelet"},  o_wavelet,        64'd0);
    endtask

    // scoreboard monitor: one frame result per o_done pulse
    always @(negedge clk) begin
        if (rst === 1'b1 && o_done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL done_unexpected: got o_done=1 want 0 (cycle %0d)", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("done_cycle", 64'(cyc), 64'(mon_e.cyc));
                check("frame_wavelet", o_wavelet, mon_e.w);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int          s;
        logic [63:0] old_w;

        for (int f = 0; f < NF; f++)
            for (int i = 0; i < N_TAB[f]; i++) begin
                tr_tap.push_back(i);
                tr_coef.push_back(BASE_TAB[f] + i);
            end

        rst = 1'b0;
        i_start_calc = 1'b0;
        fill_const(8'sd0, 8'sd0);
        repeat (3) tick();
        check_quiet("reset");
        rst = 1'b1;
        tick();

        // all ones, with full address and busy trace
        fill_const(8'sd1, 8'sd1);
        s = cyc;
        start_frame();
        for (int k = 1; k <= 326; k++) begin
            check("busy_trace", 64'(o_busy), 64'(k <= 325));
            check("tap_trace",  64'(o_tap_addr),  64'((k <= 324) ? tr_tap[k-1]  : 0));
            check("coef_trace", 64'(o_coef_addr), 64'((k <= 324) ? tr_coef[k-1] : 0));
            tick();
        end
        wait_idle();
        check("overrun_clear", 64'(o_overrun), 64'd0);

        // single product on channel 0, write latency and hold of other channels
        fill_const(8'sd0, 8'sd0);
        tap_mem[0]  = 8'sd127;
        coef_mem[0] = 8'sd127;
        old_w = prev_w;
        s = cyc;
        start_frame();
        repeat (3) tick();
        check("ch0_before_write", 64'(o_wavelet[7:0]), 64'(old_w[7:0]));
        tick();
        check("ch0_at_cycle5", 64'(o_wavelet[7:0]), 64'h3F);
        check("ch1_7_hold", 64'(o_wavelet[63:8]), 64'(old_w[63:8]));
        wait_idle();

        // negative sum across filter 7
        fill_const(-8'sd128, 8'sd0);
        for (int i = 184; i < 324; i++) coef_mem[i] = 8'sd127;
        start_frame();
        wait_idle();

        // overrun: start at cycle 100 ignored, start in done cycle accepted
        fill_random();
        s = cyc;
        start_frame();
        repeat (99) tick();
        check("overrun_before", 64'(o_overrun), 64'd0);
        i_start_calc = 1'b1;
        tick();
        i_start_calc = 1'b0;
        check("overrun_set", 64'(o_overrun), 64'd1);
        check("busy_after_reject", 64'(o_busy), 64'd1);
        while (cyc < s + 326) tick();
        check("done_at_326", 64'(o_done), 64'd1);
        start_frame();
        check("busy_after_done_start", 64'(o_busy), 64'd1);
        wait_idle();
        check("overrun_sticky", 64'(o_overrun), 64'd1);

        // reset at cycle 150 abandons the frame
        fill_random();
        s = cyc;
        start_frame();
        while (cyc < s + 150) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        void'(exp_q.pop_back());
        check_quiet("midreset");
        repeat (400) tick();
        check("midreset_stays_idle", 64'(o_busy), 64'd0);

        for (int r = 0; r < 3; r++) begin
            fill_random();
            repeat ($urandom_range(0, 5)) tick();
            start_frame();
            wait_idle();
        end

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
